// File: rtl/decade_count_ctrl.sv
// decade_count_ctrl
//   Command-driven sequencer around a cascaded BCD event counter of DIGITS
//   mod-10 digits. A host loads a BCD target, the block counts qualified
//   event_in pulses until the count equals the target, then holds a
//   completion until the host takes it.
//
//   Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid and ready are both high. cmd_ready is high only in IDLE. done_valid
//   is high for the whole of DONE. Once raised, done_valid stays high until
//   the transfer happens. done_ready is always accepted in DONE.
//
//   Optional feature: define DECADE_AUTO_RELOAD_EN. A successful completion
//   then restarts counting from 0 against the same target, and only cmd_abort
//   returns the block to IDLE. Rejected (invalid-target) completions still
//   return to IDLE.
//
//   state_dbg mirrors the FSM state register for checkers and debug.

module decade_count_ctrl #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4*DIGITS-1:0]   cmd_target,
    input  logic                  cmd_abort,
    input  logic                  event_in,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick,
    output logic                  busy,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  done_err,
    output logic [1:0]            state_dbg
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   count_q;
    logic [W-1:0]   count_next;
    logic [W-1:0]   target_q;
    logic [W-1:0]   target_next;
    logic           tick_q;
    logic           tick_next;
    logic           err_q;
    logic           err_next;

    // Incremented count and its per-digit carry chain. carry[k] is high when
    // digits 0..k-1 are all 9, i.e. digit k must step on this increment.
    logic [W-1:0]   count_inc;
    logic [DIGITS:0] carry;
    logic [DIGITS-1:0] digit_bad;
    logic           target_bad;
    logic           event_ok;

    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] digit;
        logic       at_nine;

        assign digit   = count_q[4*k +: 4];
        assign at_nine = (digit == 4'd9);

        // A digit at 9 wraps to 0 and carries into the next digit; the top
        // digit's carry simply falls off, so 10^DIGITS-1 wraps to 0.
        assign count_inc[4*k +: 4] = carry[k] ? (at_nine ? 4'd0 : digit + 4'd1)
                                              : digit;
        assign carry[k+1] = carry[k] & at_nine;

        // Any nibble above 9 makes the requested target unreachable.
        assign digit_bad[k] = (cmd_target[4*k +: 4] > 4'd9);
    end

    assign target_bad = |digit_bad;
    assign event_ok   = event_in & ~hold;

    // State register; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus next values for the count, target, tick and
    // error registers.
    always_comb begin
        state_next  = state;
        count_next  = count_q;
        target_next = target_q;
        tick_next   = 1'b0;
        err_next    = err_q;

        case (state)
            IDLE: begin
                // count_bcd keeps its last value while idle so the host can
                // read the final count after a completion.
                if (cmd_valid) begin
                    target_next = cmd_target;
                    count_next  = '0;
                    if (target_bad) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = RUN;
                        err_next   = 1'b0;
                    end
                end
            end

            RUN: begin
                // Abort wins over a terminal event in the same cycle: the
                // event is dropped and no completion is issued.
                if (cmd_abort) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (event_ok) begin
                    count_next = count_inc;
                    tick_next  = carry[1];
                    // Compare the incremented value so done_valid rises in
                    // the very first cycle that count_bcd equals the target.
                    // A zero target therefore needs a full wrap.
                    if (count_inc == target_q) begin
                        state_next = DONE;
                        err_next   = 1'b0;
                    end
                end
            end

            DONE: begin
                // Count frozen; events, commands and abort are ignored.
                if (done_ready) begin
                    err_next = 1'b0;
`ifdef DECADE_AUTO_RELOAD_EN
                    if (err_q) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RUN;
                        count_next = '0;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
                err_next   = 1'b0;
            end
        endcase
    end

    // Datapath registers: count, latched target, tick pulse and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            target_q <= '0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_next;
            target_q <= target_next;
            tick_q   <= tick_next;
            err_q    <= err_next;
        end
    end

    // All outputs come from registers or a decode of the state register.
    assign count_bcd  = count_q;
    assign tick       = tick_q;
    assign busy       = (state == RUN);
    assign cmd_ready  = (state == IDLE);
    assign done_valid = (state == DONE);
    assign done_err   = err_q;
    assign state_dbg  = state;

endmodule
